demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel in bits.
REQ-002 Parameter CNT_W, default 8, width of each per-channel delivery counter.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port in_valid, input, 1, upstream offers a word.
REQ-006 Port in_ready, output, 1, block can accept the offered word this cycle.
REQ-007 Port in_data, input, WIDTH, word to route.
REQ-008 Port in_sel, input, 2, destination channel 0..3.
REQ-009 Port out_valid, output, 4, bit k: channel k holds a word.
REQ-010 Port out_ready, input, 4, bit k: consumer k takes the word this cycle.
REQ-011 Port out_data, output, 4*WIDTH, channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Port out_count, output, 4*CNT_W, channel k delivery count occupies bits [k*CNT_W +: CNT_W].

Function
REQ-013 The block SHALL hold one one-entry slot per channel, with states EMPTY and FULL; out_valid[k] = (slot k FULL).
REQ-014 An input handshake occurs when in_valid and in_ready are both 1; in_data and in_sel SHALL be sampled only then.
REQ-015 The block SHALL drive in_ready = (slot[in_sel] EMPTY) or out_ready[in_sel]; this combinational path from out_ready to in_ready is intended.
REQ-016 On an input handshake to channel k, slot k SHALL be FULL with out_data[k] = in_data on the next cycle, giving a latency of 1 clock.
REQ-017 An output handshake on channel k occurs when out_valid[k] and out_ready[k] are both 1; slot k SHALL go EMPTY next cycle unless it is refilled in the same cycle.
REQ-018 Simultaneous output handshake and input handshake on the same channel SHALL leave the slot FULL with the new word, with no bubble.
REQ-019 While out_valid[k] is 1 and out_ready[k] is 0, out_data[k] SHALL remain stable.
REQ-020 When slot k is EMPTY, out_data[k] SHALL hold its last loaded value.
REQ-021 Channels SHALL be independent; a stalled channel SHALL NOT block input handshakes addressed to other channels.
REQ-022 in_valid = 0 SHALL cause no state change except slot drains.
REQ-023 out_count[k] SHALL increment by 1 on each output handshake on channel k.
REQ-024 out_count[k] SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-025 out_ready[k] asserted while slot k is EMPTY SHALL be ignored and SHALL NOT change the counter.

Reset
REQ-026 Asserting rst_n = 0 SHALL immediately set all slots EMPTY, out_valid = 0, out_data = 0 and out_count = 0, regardless of the clock.
REQ-027 Reset mid-operation SHALL discard buffered words; no output handshake SHALL be reported for them.
REQ-028 in_ready SHALL be 1 during reset, but no handshake SHALL be taken while rst_n = 0.
REQ-029 Normal operation SHALL resume on the first rising clk edge after rst_n returns to 1.

Structure
REQ-030 A shared package demux_pkg SHALL hold the channel count constant (4), the select width constant (2), the slot state enum (EMPTY, FULL) and the default WIDTH and CNT_W values.
REQ-031 One sub-module, demux_slot, SHALL implement a single channel: the slot state, data register and delivery counter.
REQ-032 demux_slot SHALL be instantiated four times; the top SHALL hold only the select decode and the in_ready mux.

Verification
REQ-033 After reset, send in_data=4'hA, in_sel=2 with out_ready=4'b0000 -> next cycle out_valid=4'b0100, out_data[2]=4'hA, out_count all 0.
REQ-034 With channel 1 FULL and out_ready[1]=0, offer in_sel=1 -> in_ready=0 and data held; then offer in_sel=3, in_data=4'h5 -> accepted, out_valid=4'b1010.
REQ-035 With channel 0 FULL (4'h3) and out_ready[0]=1, offer in_data=4'h7, in_sel=0 -> in_ready=1, next cycle out_valid[0]=1, out_data[0]=4'h7, out_count[0]=1.
REQ-036 Run 256 back-to-back deliveries on channel 3 with out_ready=4'b1111 -> out_count[3] reads 255 and then wraps to 0; the other counters stay 0.
REQ-037 Fill all four slots, then pulse rst_n low mid-cycle -> out_valid=0, out_data=0 and out_count=0 immediately, with no output handshakes counted.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the four-channel demux router.
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry slot, its data register and a wrapping delivery counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  slot_state_t      state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;
  logic             take;

  // Ready is only honoured while the slot actually holds a word.
  assign take  = (state_reg == FULL) && ready;
  assign valid = (state_reg == FULL);
  assign data  = data_reg;
  assign count = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // A refill in the same cycle as a drain wins, so the slot stays FULL without a bubble.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = FULL;
    end else if (take) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (load) begin
        data_reg <= load_data;
      end
      if (take) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_router.sv
// Routes one input stream to four independent one-entry output slots selected by in_sel.
module demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  logic              in_fire;
  logic [NUM_CH-1:0] load;

  // Accept when the addressed slot is empty or is being drained this same cycle.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign in_fire  = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load[gi] = in_fire && (in_sel == SEL_W'(gi));

      demux_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[gi]),
        .load_data(in_data),
        .ready    (out_ready[gi]),
        .valid    (out_valid[gi]),
        .data     (out_data[gi*WIDTH +: WIDTH]),
        .count    (out_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router with hand-computed expectations.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_count;

  int n_checks = 0;
  int n_err    = 0;

  demux_router #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 4'hF, 4'b0000);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_count", out_count, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("rst_no_take", 32'(out_valid), 32'h0);
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Single word to channel 2
    drive(1'b1, 2'd2, 4'hA, 4'b0000);
    chk("c2_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("c2_valid", 32'(out_valid), 32'h4);
    chk("c2_data", 32'(out_data[11:8]), 32'hA);
    chk("c2_count0", out_count, 32'h0);

    // Drain channel 2; data register keeps the last word
    drive(1'b0, 2'd0, 4'h0, 4'b0100);
    step();
    chk("c2_drain_valid", 32'(out_valid), 32'h0);
    chk("c2_drain_count", out_count, 32'h0001_0000);
    chk("c2_hold_data", 32'(out_data[11:8]), 32'hA);

    // Ready on an empty slot must not count
    drive(1'b0, 2'd0, 4'h0, 4'b0100);
    step();
    chk("c2_empty_ready", out_count, 32'h0001_0000);

    // Stall channel 1, others still accept
    drive(1'b1, 2'd1, 4'h9, 4'b0000);
    step();
    chk("c1_valid", 32'(out_valid), 32'h2);
    drive(1'b1, 2'd1, 4'hC, 4'b0000);
    chk("c1_stall_ready", 32'(in_ready), 32'h0);
    step();
    chk("c1_stall_data", 32'(out_data[7:4]), 32'h9);
    chk("c1_stall_valid", 32'(out_valid), 32'h2);
    drive(1'b1, 2'd3, 4'h5, 4'b0000);
    chk("c3_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("c3_valid", 32'(out_valid), 32'hA);
    chk("c3_data", 32'(out_data[15:12]), 32'h5);

    // Channel 0: load, then refill while draining (no bubble)
    drive(1'b1, 2'd0, 4'h3, 4'b0000);
    step();
    chk("c0_load_data", 32'(out_data[3:0]), 32'h3);
    drive(1'b1, 2'd0, 4'h7, 4'b0001);
    chk("c0_pass_ready", 32'(in_ready), 32'h1);
    step();
    chk("c0_pass_valid", 32'(out_valid), 32'hB);
    chk("c0_pass_data", 32'(out_data[3:0]), 32'h7);
    chk("c0_pass_count", out_count, 32'h0001_0001);

    // Fill channel 2 too, then reset mid-cycle
    drive(1'b1, 2'd2, 4'h6, 4'b0000);
    step();
    chk("full_valid", 32'(out_valid), 32'hF);
    chk("full_data", 32'(out_data), 32'h5697);
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_count", out_count, 32'h0);
    rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_count", out_count, 32'h0);

    // 256 back-to-back deliveries on channel 3
    for (int i = 0; i <= 256; i++) begin
      drive(i < 256, 2'd3, 4'(i), 4'b1111);
      if (i < 256) chk($sformatf("b2b_ready_%0d", i), 32'(in_ready), 32'h1);
      step();
      if (i < 256) begin
        chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'h8);
        chk($sformatf("b2b_data_%0d", i), 32'(out_data[15:12]), 32'(i % 16));
        chk($sformatf("b2b_cnt_%0d", i), 32'(out_count[31:24]), 32'(i));
      end
    end
    chk("wrap_count", out_count, 32'h0);
    chk("wrap_valid", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
